sdf_twiddle_ctrl: RTL and testbench

- Parametrised control and twiddle generator for one radix-2 single-delay-feedback (R2SDF, decimation-in-frequency) FFT stage.
- Counts accepted samples within each 2*D-sample block, where D is the stage delay-line length.
- Reports the stage phase (IDLE/FILL/BUTTERFLY) and supplies the fixed-point twiddle for the current sample.
- One instance per pipeline stage; every instance builds the same quarter-wave cosine table and differs only in STAGE_DELAY.

---
 rtl/sdf_twiddle_ctrl.sv | 114 +++++++++++
 tb/tb_sdf_twiddle_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sdf_twiddle_ctrl.sv
// Control and twiddle generator for one R2SDF (DIF) FFT stage: block position counter,
// stage phase and quarter-wave-folded fixed-point twiddle, all combinational per sample.
module sdf_twiddle_ctrl #(
    parameter int unsigned N_FFT       = 256,
    parameter int unsigned STAGE_DELAY = 128,
    parameter int unsigned TW_W        = 24,
    parameter int unsigned FRAC        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            frame_sync,
    input  logic            inverse,
    output logic [1:0]      state,
    output logic [TW_W-1:0] w_r,
    output logic [TW_W-1:0] w_i,
    output logic            blk_last
);

    localparam int unsigned PW     = $clog2(2 * STAGE_DELAY);
    localparam int unsigned QN     = N_FFT / 4;
    localparam int unsigned TIW    = $clog2(QN + 1);
    localparam int unsigned STRIDE = N_FFT / (2 * STAGE_DELAY);
    localparam logic signed [TW_W-1:0] ONE = TW_W'(1 << FRAC);

    if ((N_FFT < 4) || ((N_FFT & (N_FFT - 1)) != 0)) begin : g_err_n
        $error("sdf_twiddle_ctrl: N_FFT must be a power of two >= 4");
    end
    if ((STAGE_DELAY < 1) || ((STAGE_DELAY & (STAGE_DELAY - 1)) != 0) || (STAGE_DELAY > N_FFT / 2)) begin : g_err_d
        $error("sdf_twiddle_ctrl: STAGE_DELAY must be a power of two in 1..N_FFT/2");
    end
    if (TW_W < FRAC + 2) begin : g_err_w
        $error("sdf_twiddle_ctrl: TW_W must be >= FRAC+2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_BFLY = 2'd2
    } state_e;

    // Taylor series keeps the table independent of simulator math builtins; x <= pi/2 here.
    function automatic int cos_q(input int unsigned i);
        real x, term, sum, sc, v;
        x    = 2.0 * 3.14159265358979323846 * i / N_FFT;
        term = 1.0;
        sum  = 1.0;
        for (int unsigned n = 1; n <= 14; n++) begin
            term = -term * x * x / ((2.0 * n - 1.0) * (2.0 * n));
            sum  = sum + term;
        end
        sc = 1.0;
        for (int unsigned n = 0; n < FRAC; n++) sc = sc * 2.0;
        v = sum * sc;
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    logic signed [TW_W-1:0] w_cos_tab [0:QN];
    for (genvar g = 0; g <= QN; g++) begin : g_tab
        localparam int CV = cos_q(g);
        assign w_cos_tab[g] = TW_W'(CV);
    end

    logic [PW-1:0]          r_pos;
    logic                   r_started;
    logic [PW-1:0]          w_eff_pos;
    state_e                 w_state;
    logic [31:0]            w_k;
    logic [31:0]            w_m;
    logic signed [TW_W-1:0] w_cos;
    logic signed [TW_W-1:0] w_sin;

    // frame_sync takes priority over the natural 2D wrap of the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos     <= '0;
            r_started <= 1'b0;
        end else if (in_valid) begin
            r_started <= 1'b1;
            r_pos     <= frame_sync ? PW'(1) : r_pos + PW'(1);
        end
    end

    assign w_eff_pos = (in_valid && frame_sync) ? '0 : r_pos;

    always_comb begin
        if (!r_started)            w_state = ST_IDLE;
        else if (w_eff_pos[PW-1])  w_state = ST_BFLY;
        else                       w_state = ST_FILL;
    end

    // m < N/2: fold the second quadrant onto the table with a negated cosine.
    always_comb begin
        w_k   = 32'(w_eff_pos) & (STAGE_DELAY - 1);
        w_m   = w_k * STRIDE;
        w_cos = ONE;
        w_sin = '0;
        if (w_state == ST_FILL) begin
            if (w_m <= QN) begin
                w_cos = w_cos_tab[TIW'(w_m)];
                w_sin = w_cos_tab[TIW'(QN - w_m)];
            end else begin
                w_cos = -w_cos_tab[TIW'(N_FFT / 2 - w_m)];
                w_sin = w_cos_tab[TIW'(w_m - QN)];
            end
        end
    end

    assign state    = w_state;
    assign w_r      = w_cos;
    assign w_i      = inverse ? w_sin : -w_sin;
    assign blk_last = in_valid && (w_eff_pos == PW'(2 * STAGE_DELAY - 1));

endmodule

// File: tb/tb_sdf_twiddle_ctrl.sv
// Scoreboard bench for sdf_twiddle_ctrl: three stages (D=128, 2, 1) share stimulus;
// expectations are queued per stage at drive time and popped by a negedge monitor.
module tb_sdf_twiddle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic frame_sync = 1'b0;
    logic inverse = 1'b0;

    logic [1:0]  st_a, st_b, st_c;
    logic [23:0] wr_a, wi_a, wr_b, wi_b, wr_c, wi_c;
    logic        bl_a, bl_b, bl_c;

    always #5 clk = ~clk;

    sdf_twiddle_ctrl #(.N_FFT(256), .STAGE_DELAY(128), .TW_W(24), .FRAC(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_sync(frame_sync), .inverse(inverse),
        .state(st_a), .w_r(wr_a), .w_i(wi_a), .blk_last(bl_a));
    sdf_twiddle_ctrl #(.N_FFT(256), .STAGE_DELAY(2), .TW_W(24), .FRAC(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_sync(frame_sync), .inverse(inverse),
        .state(st_b), .w_r(wr_b), .w_i(wi_b), .blk_last(bl_b));
    sdf_twiddle_ctrl #(.N_FFT(256), .STAGE_DELAY(1), .TW_W(24), .FRAC(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_sync(frame_sync), .inverse(inverse),
        .state(st_c), .w_r(wr_c), .w_i(wi_c), .blk_last(bl_c));

    typedef struct {
        logic [1:0]         st;
        logic signed [23:0] wr;
        logic signed [23:0] wi;
        logic               bl;
        bit                 tw;
        int                 pos;
        string              nm;
    } exp_t;

    exp_t  qa[$], qb[$], qc[$];
    bit    chk = 1'b0;
    bit    started = 1'b0;
    int    pa = 0, pb = 0, pc = 0;
    int    n_vec = 0, n_bad = 0;
    string phase = "reset";

    // Hand-derived twiddles for N=256, FRAC=8 (forward); unlisted FILL positions skip the twiddle check.
    function automatic exp_t mk(input int d, input int eff, input bit v, input bit inv, input string nm);
        exp_t e;
        int   k;
        k     = eff % d;
        e.st  = !started ? 2'd0 : ((eff >= d) ? 2'd2 : 2'd1);
        e.bl  = v && (eff == 2 * d - 1);
        e.tw  = 1'b1;
        e.wr  = 256;
        e.wi  = 0;
        e.pos = eff;
        e.nm  = nm;
        if (e.st == 2'd1) begin
            if (d == 128) begin
                case (k)
                    0:   begin e.wr = 256;  e.wi = 0;    end
                    1:   begin e.wr = 256;  e.wi = -6;   end
                    16:  begin e.wr = 237;  e.wi = -98;  end
                    32:  begin e.wr = 181;  e.wi = -181; end
                    64:  begin e.wr = 0;    e.wi = -256; end
                    96:  begin e.wr = -181; e.wi = -181; end
                    127: begin e.wr = -256; e.wi = -6;   end
                    default: e.tw = 1'b0;
                endcase
            end else if (d == 2 && k == 1) begin
                e.wr = 0;
                e.wi = -256;
            end
        end
        if (inv) e.wi = -e.wi;
        return e;
    endfunction

    task automatic expect_all(input bit v, input bit fs);
        bit sync;
        sync = v && fs;
        qa.push_back(mk(128, sync ? 0 : pa, v, inverse, {"A.", phase}));
        qb.push_back(mk(2,   sync ? 0 : pb, v, inverse, {"B.", phase}));
        qc.push_back(mk(1,   sync ? 0 : pc, v, inverse, {"C.", phase}));
    endtask

    task automatic step(input bit v, input bit fs, input bit inv);
        @(posedge clk);
        #1;
        in_valid   = v;
        frame_sync = fs;
        inverse    = inv;
        expect_all(v, fs);
        chk = 1'b1;
        if (v) begin
            started = 1'b1;
            pa = fs ? 1 : (pa + 1) % 256;
            pb = fs ? 1 : (pb + 1) % 4;
            pc = fs ? 1 : (pc + 1) % 2;
        end
    endtask

    task automatic cmp(input exp_t e, input logic [1:0] st, input logic signed [23:0] wr,
                       input logic signed [23:0] wi, input logic bl);
        n_vec++;
        if (st !== e.st || bl !== e.bl || (e.tw && (wr !== e.wr || wi !== e.wi))) begin
            n_bad++;
            $display("FAIL %s pos=%0d: got state=%0d w=(%0d,%0d) blk_last=%0b, want state=%0d w=(%0d,%0d) blk_last=%0b%s",
                     e.nm, e.pos, st, wr, wi, bl, e.st, e.wr, e.wi, e.bl, e.tw ? "" : " (w unchecked)");
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (qa.size() > 0) cmp(qa.pop_front(), st_a, wr_a, wi_a, bl_a);
            if (qb.size() > 0) cmp(qb.pop_front(), st_b, wr_b, wi_b, bl_b);
            if (qc.size() > 0) cmp(qc.pop_front(), st_c, wr_c, wi_c, bl_c);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        phase = "idle";
        repeat (10) step(1'b0, 1'b0, 1'b0);

        phase = "cont";
        repeat (512) step(1'b1, 1'b0, 1'b0);

        phase = "inv1";
        repeat (256) step(1'b1, 1'b0, 1'b1);
        phase = "inv0";
        repeat (256) step(1'b1, 1'b0, 1'b0);

        phase = "gap";
        repeat (100) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end

        phase = "sync_novalid";
        step(1'b0, 1'b1, 1'b0);

        phase = "to77";
        for (int i = 0; i < 256 && pa != 77; i++) step(1'b1, 1'b0, 1'b0);
        phase = "sync77";
        step(1'b1, 1'b1, 1'b0);
        phase = "after_sync";
        repeat (6) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Reset asserted mid-cycle: the negedge monitor samples before any clock edge.
        phase = "async_rst";
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        started  = 1'b0;
        pa = 0; pb = 0; pc = 0;
        expect_all(1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        phase = "post_rst";
        repeat (3) step(1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d unchecked expectations, want 0", qa.size() + qb.size() + qc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
